fp_mul_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 binary multiplier; successor to the combinational FP multiply.
//  3-stage pipeline with valid/ready flow control and round-to-nearest-even (RNE).

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_class.sv | 48 ++++
 rtl/fp_mul_pipe.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constant helpers for the binary floating-point datapath.
// Width defaults, bias/exponent-range helpers, operand class enum and canonical quiet NaN.
package fp_pkg;

  localparam int N_EXP_DEF = 11;
  localparam int N_MAN_DEF = 52;
  localparam int QNAN_W    = 128;

  typedef enum logic [2:0] {
    CLS_NAN,
    CLS_INF,
    CLS_ZERO,
    CLS_DNORM,
    CLS_NORM
  } fp_cls_e;

  function automatic int fp_bias(input int n_exp);
    return (1 << (n_exp - 1)) - 1;
  endfunction

  function automatic int fp_emin(input int n_exp);
    return 1 - fp_bias(n_exp);
  endfunction

  function automatic int fp_emax(input int n_exp);
    return fp_bias(n_exp);
  endfunction

  // Positive quiet NaN: all-ones exponent plus the top fraction bit.
  function automatic logic [QNAN_W-1:0] fp_qnan(input int n_exp, input int n_man);
    logic [QNAN_W-1:0] ones;
    ones = (QNAN_W'(1) << (n_exp + 1)) - QNAN_W'(1);
    return ones << (n_man - 1);
  endfunction

endpackage

// File: rtl/fp_class.sv
// Operand classifier: unbiased exponent, significand with hidden bit, and class.
// With FP_MUL_PIPE_DNORM_EN subnormals keep exponent EMIN and hidden bit 0; otherwise they read as zero.
module fp_class
  import fp_pkg::*;
#(
  parameter int N_EXP = N_EXP_DEF,
  parameter int N_MAN = N_MAN_DEF
) (
  input  logic [N_EXP+N_MAN:0]       x,
  output logic signed [N_EXP+1:0]    expo,
  output logic [N_MAN:0]             man,
  output fp_cls_e                    cls
);

  localparam int EW = N_EXP + 2;
  localparam logic signed [EW-1:0] E_BIAS = EW'(fp_bias(N_EXP));
`ifdef FP_MUL_PIPE_DNORM_EN
  localparam logic signed [EW-1:0] E_MIN = EW'(fp_emin(N_EXP));
`endif

  logic [N_EXP-1:0] ef;
  logic [N_MAN-1:0] ff;

  assign ef = x[N_EXP+N_MAN-1:N_MAN];
  assign ff = x[N_MAN-1:0];

  always_comb begin
    expo = $signed({2'b00, ef}) - E_BIAS;
    man  = {1'b1, ff};
    cls  = CLS_NORM;
    if (ef == {N_EXP{1'b1}}) begin
      cls = (ff == '0) ? CLS_INF : CLS_NAN;
    end else if (ef == '0) begin
      if (ff == '0) begin
        cls = CLS_ZERO;
      end else begin
`ifdef FP_MUL_PIPE_DNORM_EN
        cls  = CLS_DNORM;
        expo = E_MIN;
        man  = {1'b0, ff};
`else
        cls  = CLS_ZERO;
`endif
      end
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier, round-to-nearest-even, valid/ready handshake.
// Define FP_MUL_PIPE_DNORM_EN for gradual underflow; the default build flushes subnormals to zero.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int N_EXP = N_EXP_DEF,
  parameter int N_MAN = N_MAN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_EXP+N_MAN:0]  a,
  input  logic [N_EXP+N_MAN:0]  b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_EXP+N_MAN:0]  p,
  output logic                  nan,
  output logic                  inf,
  output logic                  zero,
  output logic                  dnorm,
  output logic                  norm,
  output logic                  f_inv,
  output logic                  f_ovf,
  output logic                  f_unf,
  output logic                  f_inx
);

  localparam int W  = N_EXP + N_MAN + 1;
  localparam int EW = N_EXP + 2;
  localparam int PW = 2 * N_MAN + 2;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_MIN  = EW'(fp_emin(N_EXP));
  localparam logic signed [EW-1:0] E_MAX  = EW'(fp_emax(N_EXP));
  localparam logic signed [EW-1:0] E_BIAS = EW'(fp_bias(N_EXP));
  localparam logic [W-1:0]         QNAN   = W'(fp_qnan(N_EXP, N_MAN));

  assign in_ready = !out_valid || out_ready;

  // ---------------- S1: classify, specials, exponent sum, full product
  logic signed [EW-1:0] ea, eb;
  logic [N_MAN:0]       ma, mb;
  fp_cls_e              ca, cb;
  logic                 spc, inv;
  fp_cls_e              spc_cls;
  logic                 snan;

  fp_class #(.N_EXP(N_EXP), .N_MAN(N_MAN)) u_cls_a (.x(a), .expo(ea), .man(ma), .cls(ca));
  fp_class #(.N_EXP(N_EXP), .N_MAN(N_MAN)) u_cls_b (.x(b), .expo(eb), .man(mb), .cls(cb));

  assign snan = (ca == CLS_NAN && !ma[N_MAN-1]) || (cb == CLS_NAN && !mb[N_MAN-1]);

  always_comb begin
    spc     = 1'b1;
    spc_cls = CLS_NORM;
    inv     = 1'b0;
    if (ca == CLS_NAN || cb == CLS_NAN) begin
      spc_cls = CLS_NAN;
      inv     = snan;
    end else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
      spc_cls = CLS_NAN;
      inv     = 1'b1;
    end else if (ca == CLS_INF || cb == CLS_INF) begin
      spc_cls = CLS_INF;
    end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
      spc_cls = CLS_ZERO;
    end else begin
      spc = 1'b0;
    end
  end

  logic                 v1, s1_sgn, s1_spc, s1_inv;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;
  fp_cls_e              s1_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_sgn  <= 1'b0;
      s1_exp  <= '0;
      s1_prod <= '0;
      s1_spc  <= 1'b0;
      s1_cls  <= CLS_ZERO;
      s1_inv  <= 1'b0;
    end else if (in_ready) begin
      v1      <= in_valid;
      s1_sgn  <= a[W-1] ^ b[W-1];
      s1_exp  <= ea + eb;
      s1_prod <= PW'(ma) * PW'(mb);
      s1_spc  <= spc;
      s1_cls  <= spc_cls;
      s1_inv  <= inv;
    end
  end

  // ---------------- S2: normalise, denormalise, guard/round/sticky
  logic [PW-1:0]        m_n;
  logic signed [EW-1:0] e_n;
  logic                 lost, tiny_d;
`ifdef FP_MUL_PIPE_DNORM_EN
  int lz, shamt;
`endif

  always_comb begin
    lost = 1'b0;
    if (s1_prod[PW-1]) begin
      m_n = s1_prod;
      e_n = s1_exp + E_ONE;
    end else begin
      m_n = s1_prod << 1;
      e_n = s1_exp;
    end
`ifdef FP_MUL_PIPE_DNORM_EN
    // Subnormal operands can leave leading zeros; pull them up as far as EMIN allows.
    lz = PW;
    for (int i = 0; i < PW; i++) begin
      if (m_n[i]) lz = PW - 1 - i;
    end
    shamt = 0;
    if (e_n > E_MIN) begin
      shamt = int'(e_n - E_MIN);
      if (lz < shamt) shamt = lz;
      m_n = m_n << shamt;
      e_n = e_n - EW'(shamt);
    end else if (e_n < E_MIN) begin
      shamt = int'(E_MIN - e_n);
      if (shamt > N_MAN + 2) shamt = N_MAN + 2;
      lost = |(m_n & ((PW'(1) << shamt) - PW'(1)));
      m_n  = m_n >> shamt;
      e_n  = E_MIN;
    end
    tiny_d = !m_n[PW-1];
`else
    tiny_d = e_n < E_MIN;
`endif
  end

  logic                 v2, s2_sgn, s2_spc, s2_inv, s2_g, s2_r, s2_s, s2_tiny;
  logic signed [EW-1:0] s2_exp;
  logic [N_MAN:0]       s2_man;
  fp_cls_e              s2_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      s2_sgn  <= 1'b0;
      s2_exp  <= '0;
      s2_man  <= '0;
      s2_g    <= 1'b0;
      s2_r    <= 1'b0;
      s2_s    <= 1'b0;
      s2_tiny <= 1'b0;
      s2_spc  <= 1'b0;
      s2_cls  <= CLS_ZERO;
      s2_inv  <= 1'b0;
    end else if (in_ready) begin
      v2      <= v1;
      s2_sgn  <= s1_sgn;
      s2_exp  <= e_n;
      s2_man  <= m_n[PW-1:N_MAN+1];
      s2_g    <= m_n[N_MAN];
      s2_r    <= m_n[N_MAN-1];
      s2_s    <= (|m_n[N_MAN-2:0]) | lost;
      s2_tiny <= tiny_d;
      s2_spc  <= s1_spc;
      s2_cls  <= s1_cls;
      s2_inv  <= s1_inv;
    end
  end

  // ---------------- S3: round, overflow/underflow, final encoding
  logic                 inc;
  logic [N_MAN+1:0]     mr;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         p_d;
  fp_cls_e              cls_d;
  logic                 inv_d, ovf_d, unf_d, inx_d;

  always_comb begin
    inc = s2_g && (s2_r || s2_s || s2_man[0]);
    mr  = {1'b0, s2_man} + {{(N_MAN+1){1'b0}}, inc};
    e_r = s2_exp;
    // A carry out lands on 1.000..; a subnormal carrying into the hidden bit is already the smallest normal.
    if (mr[N_MAN+1]) begin
      mr  = mr >> 1;
      e_r = e_r + E_ONE;
    end
    p_d   = {s2_sgn, (mr[N_MAN] ? N_EXP'(e_r + E_BIAS) : {N_EXP{1'b0}}), mr[N_MAN-1:0]};
    cls_d = mr[N_MAN] ? CLS_NORM : ((mr[N_MAN-1:0] == '0) ? CLS_ZERO : CLS_DNORM);
    inv_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s2_g | s2_r | s2_s;
    if (s2_spc) begin
      inx_d = 1'b0;
      cls_d = s2_cls;
      case (s2_cls)
        CLS_NAN: begin
          p_d   = QNAN;
          inv_d = s2_inv;
        end
        CLS_INF: p_d = {s2_sgn, {N_EXP{1'b1}}, {N_MAN{1'b0}}};
        default: begin
          p_d   = {s2_sgn, {(W-1){1'b0}}};
          cls_d = CLS_ZERO;
        end
      endcase
    end else if (e_r > E_MAX) begin
      p_d   = {s2_sgn, {N_EXP{1'b1}}, {N_MAN{1'b0}}};
      cls_d = CLS_INF;
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
`ifdef FP_MUL_PIPE_DNORM_EN
    else begin
      unf_d = s2_tiny && inx_d;
    end
`else
    else if (s2_tiny) begin
      p_d   = {s2_sgn, {(W-1){1'b0}}};
      cls_d = CLS_ZERO;
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
      nan       <= 1'b0;
      inf       <= 1'b0;
      zero      <= 1'b0;
      dnorm     <= 1'b0;
      norm      <= 1'b0;
      f_inv     <= 1'b0;
      f_ovf     <= 1'b0;
      f_unf     <= 1'b0;
      f_inx     <= 1'b0;
    end else if (in_ready) begin
      out_valid <= v2;
      p         <= p_d;
      nan       <= (cls_d == CLS_NAN);
      inf       <= (cls_d == CLS_INF);
      zero      <= (cls_d == CLS_ZERO);
      dnorm     <= (cls_d == CLS_DNORM);
      norm      <= (cls_d == CLS_NORM);
      f_inv     <= inv_d;
      f_ovf     <= ovf_d;
      f_unf     <= unf_d;
      f_inx     <= inx_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (binary64): directed spec vectors, throttled stream,
// randomized traffic scored against an exact integer reference model, and mid-stream reset.
module tb_fp_mul_pipe;

`ifdef FP_MUL_PIPE_DNORM_EN
  localparam bit DN = 1'b1;
`else
  localparam bit DN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] p;
    logic [4:0]  cls;  // nan, inf, zero, dnorm, norm
    logic [3:0]  fl;   // inv, ovf, unf, inx
  } res_t;

  localparam logic [4:0] C_NAN = 5'b10000, C_INF = 5'b01000, C_ZERO = 5'b00100,
                         C_DNORM = 5'b00010, C_NORM = 5'b00001;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [63:0] a = '0, b = '0, p;
  logic nan, inf, zero, dnorm, norm, f_inv, f_ovf, f_unf, f_inx;

  int checks = 0, errors = 0, cyc = 0;
  res_t exp_q[$];
  int   acc_q[$];
  logic stall_prev = 1'b0, lat_chk = 1'b0, accepted = 1'b0;
  res_t held;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .p(p),
    .nan(nan), .inf(inf), .zero(zero), .dnorm(dnorm), .norm(norm),
    .f_inv(f_inv), .f_ovf(f_ovf), .f_unf(f_unf), .f_inx(f_inx)
  );

  always #5 clk = ~clk;

  function automatic res_t obs();
    return {p, nan, inf, zero, dnorm, norm, f_inv, f_ovf, f_unf, f_inx};
  endfunction

  task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Exact reference: value = M * 2^E, rounded to the quantum of the target binade.
  function automatic res_t model(input logic [63:0] x, input logic [63:0] y);
    res_t r;
    logic s, xn, yn, xi, yi, xz, yz, xs;
    logic [10:0] ex, ey;
    logic [51:0] fx, fy;
    logic [127:0] m, rr, rem, half;
    int e, msb, lead, q, sh, biased;
    logic inx;
    s  = x[63] ^ y[63];
    ex = x[62:52]; fx = x[51:0];
    ey = y[62:52]; fy = y[51:0];
    xn = (ex == 11'h7FF) && (fx != 0);
    yn = (ey == 11'h7FF) && (fy != 0);
    xi = (ex == 11'h7FF) && (fx == 0);
    yi = (ey == 11'h7FF) && (fy == 0);
    xz = (ex == 0) && ((fx == 0) || !DN);
    yz = (ey == 0) && ((fy == 0) || !DN);
    xs = (xn && !fx[51]) || (yn && !fy[51]);
    r = '0;
    if (xn || yn || (xi && yz) || (xz && yi)) begin
      r.p = 64'h7FF8000000000000; r.cls = C_NAN; r.fl[3] = xs || !(xn || yn);
      return r;
    end
    if (xi || yi) begin r.p = {s, 11'h7FF, 52'h0}; r.cls = C_INF; return r; end
    if (xz || yz) begin r.p = {s, 63'h0}; r.cls = C_ZERO; return r; end
    m = 128'({ex != 0, fx}) * 128'({ey != 0, fy});
    e = ((ex == 0) ? 1 : int'(ex)) + ((ey == 0) ? 1 : int'(ey)) - 2 * 1075;
    msb = 0;
    for (int i = 0; i < 128; i++) if (m[i]) msb = i;
    lead = msb + e;
    if (!DN && lead < -1022) begin
      r.p = {s, 63'h0}; r.cls = C_ZERO; r.fl = 4'b0011;
      return r;
    end
    q  = (lead - 52 > -1074) ? lead - 52 : -1074;
    sh = q - e;
    inx = 1'b0;
    if (sh <= 0) rr = m << (-sh);
    else if (sh > 120) begin rr = '0; inx = 1'b1; end
    else begin
      rr   = m >> sh;
      rem  = m - (rr << sh);
      half = 128'(1) << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && rr[0])) rr = rr + 128'(1);
    end
    if (rr == (128'(1) << 53)) begin rr = rr >> 1; q = q + 1; end
    if (rr >= (128'(1) << 52)) begin
      biased = q + 52 + 1023;
      if (biased >= 2047) begin
        r.p = {s, 11'h7FF, 52'h0}; r.cls = C_INF; r.fl = 4'b0101;
        return r;
      end
      r.p = {s, biased[10:0], rr[51:0]}; r.cls = C_NORM;
    end else begin
      r.p = {s, 11'h0, rr[51:0]}; r.cls = (rr == 0) ? C_ZERO : C_DNORM;
    end
    r.fl[0] = inx;
    r.fl[1] = (lead < -1022) && inx;
    return r;
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] t;
    logic [10:0] e;
    logic [51:0] f;
    t = {$urandom, $urandom};
    f = t[51:0];
    case ($urandom_range(0, 15))
      0: begin e = 11'h0; if ($urandom_range(0, 1) == 1) f = '0; end
      1: begin e = 11'h7FF; if ($urandom_range(0, 1) == 1) f = '0; end
      2, 3: e = 11'($urandom_range(1, 40));
      4, 5: e = 11'($urandom_range(2000, 2046));
      6: begin e = 11'd1023; f = '0; end
      default: e = 11'($urandom_range(900, 1150));
    endcase
    return {t[63], e, f};
  endfunction

  // One clock: drive inputs at negedge, score at negedge+1, push on accept.
  task automatic cycle(input logic v, input logic [63:0] av, input logic [63:0] bv,
                       input logic ordy, input logic hx, input res_t xv);
    res_t er;
    int t;
    @(negedge clk);
    in_valid = v; a = av; b = bv; out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_data", 128'(obs()), 128'(held));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 128'(out_valid), 128'(0));
      else begin
        er = exp_q.pop_front();
        t  = acc_q.pop_front();
        check("result", 128'(obs()), 128'(er));
        if (lat_chk) check("latency", 128'(cyc - t), 128'(3));
      end
    end
    stall_prev = out_valid && !out_ready;
    held = obs();
    accepted = in_valid && in_ready;
    if (accepted) begin
      exp_q.push_back(hx ? xv : model(av, bv));
      acc_q.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int n;
    res_t dn_exp;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_p_flags", 128'(obs()), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back-to-back, latency checked
    lat_chk = 1'b1;
    dn_exp = DN ? {64'h0008000000000000, C_DNORM, 4'b0000} : {64'h0, C_ZERO, 4'b0011};
    cycle(1, 64'h3FF8000000000000, 64'h4000000000000000, 1, 1, {64'h4008000000000000, C_NORM, 4'b0000});
    cycle(1, 64'h7FF0000000000000, 64'h0000000000000000, 1, 1, {64'h7FF8000000000000, C_NAN, 4'b1000});
    cycle(1, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 1, 1, {64'h7FF0000000000000, C_INF, 4'b0101});
    cycle(1, 64'h0010000000000000, 64'h3FE0000000000000, 1, 1, dn_exp);
    cycle(1, 64'h3FF0000000000001, 64'h3FF8000000000000, 1, 1, {64'h3FF8000000000002, C_NORM, 4'b0001});
    cycle(1, 64'hFFF0000000000000, 64'h4000000000000000, 1, 1, {64'hFFF0000000000000, C_INF, 4'b0000});
    cycle(1, 64'h7FF4000000000000, 64'h3FF0000000000000, 1, 1, {64'h7FF8000000000000, C_NAN, 4'b1000});
    cycle(1, 64'h8000000000000000, 64'h4000000000000000, 1, 1, {64'h8000000000000000, C_ZERO, 4'b0000});
    drain();
    lat_chk = 1'b0;

    // Stream 8 ops with out_ready toggling 1,0,1,0...
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      cycle(1, rnd_op(), rnd_op(), (k % 2) == 0, 0, '0);
      if (accepted) n++;
    end
    check("stream_accepted", 128'(n), 128'(8));
    drain();

    // Randomized traffic with random back-pressure
    for (int k = 0; k < 600; k++)
      cycle($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), $urandom_range(0, 9) < 7, 0, '0);
    drain();

    // Reset with operations in flight
    for (int k = 0; k < 4; k++) cycle(1, rnd_op(), rnd_op(), 1, 0, '0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 128'(out_valid), 128'(0));
    check("rst_mid_p", 128'(p), 128'(0));
    exp_q.delete();
    acc_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(0, '0, '0, 1, 0, '0);
      check("idle_after_rst", 128'(out_valid), 128'(0));
    end
    lat_chk = 1'b1;
    cycle(1, 64'h3FF8000000000000, 64'h4000000000000000, 1, 1, {64'h4008000000000000, C_NORM, 4'b0000});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
